// File: rtl/me_fetch_scheduler.sv
// me_fetch_scheduler: sequences frame-memory reads that fill the current-block
// and search-window buffers for one motion-estimation block at a time.
module me_fetch_scheduler #(
  parameter int unsigned FRAME_W_BLK = 80,
  parameter int unsigned FRAME_H_BLK = 45,
  parameter int unsigned PITCH_WORDS = 320,
  parameter int unsigned ADDR_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [13:0]       curpos,
  input  logic [ADDR_W-1:0] cur_base,
  input  logic [ADDR_W-1:0] ref_base,
  output logic              busy,
  output logic              currentfilled,
  output logic              searchfilled,
  output logic [1:0]        sw_slot_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              cur_we,
  output logic [5:0]        cur_waddr,
  output logic [31:0]       cur_wdata,
  output logic              sw_we,
  output logic [9:0]        sw_waddr,
  output logic [31:0]       sw_wdata
);

  localparam int unsigned WIN_ROWS    = 48;
  localparam int unsigned FRAME_H_PIX = FRAME_H_BLK * 16;

  typedef enum logic [2:0] {
    IDLE, CUR_REQ, CUR_DATA, SW_SEL, SW_REQ, SW_DATA, SW_PAD, DONE
  } state_t;

  state_t            state;
  logic [6:0]        bx, by;
  logic [ADDR_W-1:0] cur_base_q, ref_base_q;
  logic              prev_valid;
  logic [6:0]        prev_bx, prev_by;
  logic [3:0]        row;
  logic [1:0]        word;
  logic [5:0]        wr;
  logic [1:0]        s, s_first;

  logic [10:0]        cur_prow;
  logic [ADDR_W-1:0]  cur_addr;
  logic signed [11:0] sw_prow;
  logic [7:0]         col_p1;
  logic               seg_in_frame;
  logic [ADDR_W-1:0]  sw_addr;
  logic [1:0]         slot;
  logic [9:0]         sw_row_addr;
  logic               full_reload;
  logic [1:0]         next_s;
  logic [5:0]         next_wr;

  // Segment geometry: addresses, frame clipping, slot mapping and window step.
  always_comb begin
    cur_prow     = {by, 4'b0000} + 11'(row);
    cur_addr     = cur_base_q + ADDR_W'(cur_prow) * ADDR_W'(PITCH_WORDS)
                   + ADDR_W'({bx, 2'b00});
    // Pixel row of the window row; negative above the frame.
    sw_prow      = 12'({by, 4'b0000}) + 12'(wr) - 12'd16;
    // Block column plus one, so column -1 (left of frame) is 0.
    col_p1       = 8'(bx) + 8'(s);
    seg_in_frame = !sw_prow[11] && (sw_prow[10:0] < 11'(FRAME_H_PIX))
                   && (col_p1 != 8'd0) && (col_p1 <= 8'(FRAME_W_BLK));
    sw_addr      = ref_base_q + ADDR_W'(sw_prow[10:0]) * ADDR_W'(PITCH_WORDS)
                   + ADDR_W'({col_p1 - 8'd1, 2'b00});
    // (col + 3) mod 3 maps column -1 onto slot 2.
    slot         = 2'((col_p1 + 8'd2) % 8'd3);
    sw_row_addr  = 10'(wr) * 10'd12 + 10'({slot, 2'b00});
    full_reload  = (bx == 7'd0) || !prev_valid || (prev_bx != bx - 7'd1)
                   || (prev_by != by);
    next_s       = (s == 2'd2) ? s_first : s + 2'd1;
    next_wr      = (s == 2'd2) ? wr + 6'd1 : wr;
  end

  // Fetch sequencer with registered request, buffer-write and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      currentfilled <= 1'b0;
      searchfilled  <= 1'b0;
      sw_slot_base  <= 2'd0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      cur_we        <= 1'b0;
      cur_waddr     <= 6'd0;
      cur_wdata     <= 32'd0;
      sw_we         <= 1'b0;
      sw_waddr      <= 10'd0;
      sw_wdata      <= 32'd0;
      bx            <= 7'd0;
      by            <= 7'd0;
      cur_base_q    <= '0;
      ref_base_q    <= '0;
      prev_valid    <= 1'b0;
      prev_bx       <= 7'd0;
      prev_by       <= 7'd0;
      row           <= 4'd0;
      word          <= 2'd0;
      wr            <= 6'd0;
      s             <= 2'd0;
      s_first       <= 2'd0;
    end else begin
      cur_we <= 1'b0;
      sw_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bx            <= curpos[6:0];
            by            <= curpos[13:7];
            cur_base_q    <= cur_base;
            ref_base_q    <= ref_base;
            currentfilled <= 1'b0;
            searchfilled  <= 1'b0;
            busy          <= 1'b1;
            row           <= 4'd0;
            word          <= 2'd0;
            state         <= CUR_REQ;
          end
        end
        CUR_REQ: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= cur_addr;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            word    <= 2'd0;
            state   <= CUR_DATA;
          end
        end
        CUR_DATA: begin
          if (mem_rvalid) begin
            cur_we    <= 1'b1;
            cur_waddr <= {row, word};
            cur_wdata <= mem_rdata;
            word      <= word + 2'd1;
            if (word == 2'd3) begin
              row <= row + 4'd1;
              if (row == 4'd15) begin
                currentfilled <= 1'b1;
                state         <= SW_SEL;
              end else begin
                state <= CUR_REQ;
              end
            end
          end
        end
        SW_SEL: begin
          wr      <= 6'd0;
          word    <= 2'd0;
          s       <= full_reload ? 2'd0 : 2'd2;
          s_first <= full_reload ? 2'd0 : 2'd2;
          state   <= SW_REQ;
        end
        SW_REQ: begin
          if (!mem_req) begin
            if (wr == 6'(WIN_ROWS)) begin
              state <= DONE;
            end else if (seg_in_frame) begin
              mem_req  <= 1'b1;
              mem_addr <= sw_addr;
            end else begin
              word  <= 2'd0;
              state <= SW_PAD;
            end
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            word    <= 2'd0;
            state   <= SW_DATA;
          end
        end
        SW_DATA: begin
          if (mem_rvalid) begin
            sw_we    <= 1'b1;
            sw_waddr <= sw_row_addr + 10'(word);
            sw_wdata <= mem_rdata;
            word     <= word + 2'd1;
            if (word == 2'd3) begin
              s     <= next_s;
              wr    <= next_wr;
              state <= SW_REQ;
            end
          end
        end
        SW_PAD: begin
          sw_we    <= 1'b1;
          sw_waddr <= sw_row_addr + 10'(word);
          sw_wdata <= 32'd0;
          word     <= word + 2'd1;
          if (word == 2'd3) begin
            s     <= next_s;
            wr    <= next_wr;
            state <= SW_REQ;
          end
        end
        DONE: begin
          searchfilled <= 1'b1;
          busy         <= 1'b0;
          prev_valid   <= 1'b1;
          prev_bx      <= bx;
          prev_by      <= by;
          sw_slot_base <= 2'(bx % 7'd3);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_fetch_scheduler.sv
// tb_me_fetch_scheduler: scoreboard bench with a latency-configurable memory model.
module tb_me_fetch_scheduler;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [13:0] curpos;
  logic [23:0] cur_base, ref_base;
  logic        busy, currentfilled, searchfilled;
  logic [1:0]  sw_slot_base;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        cur_we, sw_we;
  logic [5:0]  cur_waddr;
  logic [9:0]  sw_waddr;
  logic [31:0] cur_wdata, sw_wdata;

  always #5 clk = ~clk;

  me_fetch_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .curpos(curpos),
    .cur_base(cur_base), .ref_base(ref_base), .busy(busy),
    .currentfilled(currentfilled), .searchfilled(searchfilled),
    .sw_slot_base(sw_slot_base), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .cur_we(cur_we), .cur_waddr(cur_waddr), .cur_wdata(cur_wdata),
    .sw_we(sw_we), .sw_waddr(sw_waddr), .sw_wdata(sw_wdata)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_req_q[$];
  wr_t         exp_cur_q[$];
  wr_t         exp_sw_q[$];
  logic [23:0] req_log[$];
  int          n_req, n_cwr, n_swr, n_zero, first_sw_waddr;
  int          gnt_delay = 0, beat_gap = 0, force_beats = 0;
  int          last_bx = 0, last_by = 0;
  bit          last_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [23:0] a);
    return {8'hA5, a};
  endfunction

  // Spec-level reference: expected request and buffer-write streams for one block.
  task automatic expect_job(input int bx, input int by, input logic [23:0] cb,
                            input logic [23:0] rb);
    bit          full, inf;
    int          first, prow, col, slot;
    logic [23:0] a;
    wr_t         e;
    for (int r = 0; r < 16; r++) begin
      a = cb + 24'((by * 16 + r) * 320 + bx * 4);
      exp_req_q.push_back(a);
      for (int w = 0; w < 4; w++) begin
        e.addr = 10'(r * 4 + w);
        e.data = mem_data(a + 24'(w));
        exp_cur_q.push_back(e);
      end
    end
    full  = (bx == 0) || !last_valid || (last_bx != bx - 1) || (last_by != by);
    first = full ? 0 : 2;
    for (int wr = 0; wr < 48; wr++) begin
      for (int s = first; s < 3; s++) begin
        prow = by * 16 - 16 + wr;
        col  = bx - 1 + s;
        slot = (col + 3) % 3;
        inf  = (prow >= 0) && (prow < 720) && (col >= 0) && (col < 80);
        a    = rb + 24'(prow * 320 + col * 4);
        if (inf) exp_req_q.push_back(a);
        for (int w = 0; w < 4; w++) begin
          e.addr = 10'(wr * 12 + slot * 4 + w);
          e.data = inf ? mem_data(a + 24'(w)) : 32'h0;
          exp_sw_q.push_back(e);
        end
      end
    end
  endtask

  // Memory model: grant after gnt_delay cycles, then 4 beats separated by beat_gap.
  initial begin
    int          beats_left, gap_cnt, wait_cnt;
    logic [23:0] beat_addr;
    beats_left = 0; gap_cnt = 0; wait_cnt = 0; beat_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (reset) begin
        beats_left = 0; wait_cnt = 0;
      end else if (force_beats > 0) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; force_beats--;
      end else if (beats_left > 0) begin
        if (gap_cnt > 0) gap_cnt--;
        else begin
          mem_rvalid = 1'b1; mem_rdata = mem_data(beat_addr);
          beat_addr++; beats_left--; gap_cnt = beat_gap;
        end
      end else if (mem_req) begin
        if (wait_cnt < gnt_delay) wait_cnt++;
        else begin
          mem_gnt = 1'b1; wait_cnt = 0; beats_left = 4;
          beat_addr = mem_addr; gap_cnt = beat_gap;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a request is granted or a buffer is written.
  initial begin
    logic        prev_req, prev_gnt, prev_rst;
    logic [23:0] prev_addr;
    wr_t         e;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_rst = 1'b1; prev_addr = '0;
    forever begin
      @(negedge clk); #1;
      if (!reset && !prev_rst && prev_req && !prev_gnt) begin
        check("req_hold", mem_req, 1'b1);
        check("addr_hold", mem_addr, prev_addr);
      end
      if (mem_req && mem_gnt) begin
        n_req++;
        req_log.push_back(mem_addr);
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr 0x%0h expected none", mem_addr);
        end else check("mem_addr", mem_addr, exp_req_q.pop_front());
      end
      if (cur_we) begin
        n_cwr++;
        if (exp_cur_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cur_we: got addr %0d expected none", cur_waddr);
        end else begin
          e = exp_cur_q.pop_front();
          check("cur_write", {cur_waddr, cur_wdata}, {e.addr, e.data});
        end
      end
      if (sw_we) begin
        if (n_swr == 0) first_sw_waddr = int'(sw_waddr);
        n_swr++;
        if (sw_wdata == 32'h0) n_zero++;
        if (exp_sw_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sw_we: got addr %0d expected none", sw_waddr);
        end else begin
          e = exp_sw_q.pop_front();
          check("sw_write", {sw_waddr, sw_wdata}, {e.addr, e.data});
        end
      end
      prev_req = mem_req; prev_gnt = mem_gnt; prev_rst = reset; prev_addr = mem_addr;
    end
  end

  task automatic clear_counts();
    n_req = 0; n_cwr = 0; n_swr = 0; n_zero = 0; first_sw_waddr = -1;
    req_log.delete();
  endtask

  // Runs one block fetch (called at a falling edge) and checks its totals.
  task automatic run_job(input int bx, input int by, input int exp_reqs,
                         input int exp_swr, input int exp_zero, input int exp_slot,
                         input bit poke);
    bit done;
    expect_job(bx, by, cur_base, ref_base);
    clear_counts();
    curpos = {7'(by), 7'(bx)};
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("cf_cleared", currentfilled, 1'b0);
    check("sf_cleared", searchfilled, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      if (poke && i == 50) begin
        curpos = {7'd20, 7'd20}; start = 1'b1;
      end else if (poke && i == 51) begin
        start = 1'b0; curpos = {7'(by), 7'(bx)};
      end
      @(negedge clk);
      done = searchfilled;
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: got searchfilled 0 expected 1 for block (%0d,%0d)", bx, by);
    end
    repeat (2) @(negedge clk);
    check("n_req", n_req, exp_reqs);
    check("n_cur_writes", n_cwr, 64);
    check("n_sw_writes", n_swr, exp_swr);
    check("n_zero_writes", n_zero, exp_zero);
    check("sw_slot_base", sw_slot_base, exp_slot);
    check("currentfilled", currentfilled, 1'b1);
    check("searchfilled", searchfilled, 1'b1);
    check("busy_done", busy, 1'b0);
    check("req_q_empty", exp_req_q.size(), 0);
    check("cur_q_empty", exp_cur_q.size(), 0);
    check("sw_q_empty", exp_sw_q.size(), 0);
    last_bx = bx; last_by = by; last_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; curpos = '0; cur_base = 24'h0; ref_base = 24'h010000;
    clear_counts();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", {busy, currentfilled, searchfilled, sw_slot_base, mem_req,
                          mem_addr, cur_we, sw_we}, 0);

    // Reset mid-traffic, then stray beats must not write.
    expect_job(0, 0, cur_base, ref_base);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("traffic_before_rst", n_cwr > 0, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_req_q.delete(); exp_cur_q.delete(); exp_sw_q.delete();
    check("midrst_outputs", {busy, currentfilled, searchfilled, sw_slot_base, mem_req,
                             mem_addr, cur_we, cur_waddr, cur_wdata, sw_we, sw_waddr,
                             sw_wdata}, 0);
    reset = 1'b0;
    clear_counts();
    force_beats = 6;
    repeat (10) @(negedge clk);
    check("stray_cur_writes", n_cwr, 0);
    check("stray_sw_writes", n_swr, 0);
    check("idle_after_rst", busy, 1'b0);

    // (0,0): full window, top/left clipped.
    beat_gap = 0; gnt_delay = 0;
    run_job(0, 0, 80, 576, 320, 0, 1'b0);
    check("j00_first_cur_addr", req_log[0], 24'h0);
    check("j00_last_cur_addr", req_log[15], 24'h0012C0);
    check("j00_first_sw_addr", req_log[16], 24'h010000);

    // (1,0): stripe update only.
    beat_gap = 1;
    run_job(1, 0, 48, 192, 64, 1, 1'b0);
    check("j10_first_cur_addr", req_log[0], 24'h4);
    check("j10_first_sw_addr", req_log[16], 24'h010008);
    check("j10_last_sw_addr", req_log[47], 24'h0126C8);
    check("j10_first_sw_waddr", first_sw_waddr, 8);

    // (5,3): non-sequential, under backpressure, with a start pulse while busy.
    gnt_delay = 10; beat_gap = 3;
    run_job(5, 3, 160, 576, 0, 2, 1'b1);
    check("j53_first_cur_addr", req_log[0], 24'h003C14);
    check("j53_first_sw_addr", req_log[16], 24'h012810);

    // (78,10) then (79,10): new right stripe falls outside the frame.
    gnt_delay = 0; beat_gap = 1;
    run_job(78, 10, 160, 576, 0, 0, 1'b0);
    run_job(79, 10, 16, 192, 192, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
